bus_demo_seq: RTL

Test-pattern sequencer for the demo system bus. On a single start pulse it issues NUM_WORDS back-to-back transactions to the local request port of one bus master. In write mode it writes a seeded incrementing pattern. In read mode it reads the same range back, compares each word and counts mismatches. It sits between the demo top-level start/mode/ready controls and the bus master, with a per-word watchdog so a hung slave cannot lock it up.

---
 rtl/bus_demo_seq.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/bus_demo_seq.sv
// bus_demo_seq: test-pattern sequencer for the demo system bus.
//
// One accepted start pulse issues NUM_WORDS back-to-back transactions to a
// bus master's local request port. Write mode writes seed+idx at
// BASE_ADDR+idx. Read mode reads the same range back and counts words that
// differ from seed+idx. A per-word watchdog aborts the run if a word does not
// complete within TIMEOUT_CYCLES cycles.
//
// Ports:
//   clk_i, rst_i        system clock, asynchronous active-high reset
//   start_i             run request, honoured only while ready_o=1
//   mode_i, seed_i      1=write / 0=read-compare, pattern seed (latched at start)
//   ready_o             high while idle
//   done_o              one-cycle pulse at the end of a run
//   pass_o              result of the last run
//   err_count_o         mismatches in the last read run (saturating)
//   timeout_o           last run aborted by the watchdog
//   m_valid_o, m_mode_o, m_addr_o, m_wdata_o   request to the master
//   m_ready_i           master accepts the request this cycle
//   m_done_i, m_rdata_i transaction complete pulse and its read data
//
// state  | meaning
// IDLE   | waiting for start, ready_o=1
// ISSUE  | request word idx presented until the master accepts it
// WAIT   | request accepted, waiting for m_done_i
// FINISH | one-cycle done pulse, results valid
module bus_demo_seq #(
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    NUM_WORDS      = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 16'h4000,
    parameter int                    TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [7:0]            err_count_o,
    output logic                  timeout_o,
    output logic                  m_valid_o,
    output logic                  m_mode_o,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    output logic [DATA_WIDTH-1:0] m_wdata_o,
    input  logic                  m_ready_i,
    input  logic                  m_done_i,
    input  logic [DATA_WIDTH-1:0] m_rdata_i
);

    localparam int IDX_W = 8;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  mode_q, mode_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic [7:0]            err_q, err_d;
    logic                  pass_q, pass_d;
    logic                  timeout_q, timeout_d;
    logic [WD_W-1:0]       wdog_q, wdog_d;

    logic [DATA_WIDTH-1:0] exp_data;
    logic                  wdog_expired;
    logic                  last_word;

    assign exp_data     = seed_q + DATA_WIDTH'(idx_q);
    assign wdog_expired = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign last_word    = (idx_q == IDX_W'(NUM_WORDS - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            mode_q    <= 1'b0;
            seed_q    <= '0;
            err_q     <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mode_q    <= mode_d;
            seed_q    <= seed_d;
            err_q     <= err_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            wdog_q    <= wdog_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mode_d    = mode_q;
        seed_d    = seed_q;
        err_d     = err_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        wdog_d    = wdog_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d    = mode_i;
                    seed_d    = seed_i;
                    idx_d     = '0;
                    err_d     = '0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    wdog_d    = '0;
                    state_d   = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // An accept on the expiry edge still leaves the word
                // incomplete, so expiry wins here.
                if (wdog_expired) begin
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    state_d   = S_FINISH;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                    if (m_ready_i) begin
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                // Completion takes priority over a simultaneous expiry.
                if (m_done_i) begin
                    if (!mode_q && (m_rdata_i != exp_data) && (err_q != 8'hFF)) begin
                        err_d = err_q + 8'd1;
                    end
                    if (last_word) begin
                        pass_d  = mode_q || (err_d == 8'd0);
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        wdog_d  = '0;
                        state_d = S_ISSUE;
                    end
                end else if (wdog_expired) begin
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    state_d   = S_FINISH;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request fields are zero outside ISSUE so the bus sees a quiet port.
    assign ready_o     = (state_q == S_IDLE);
    assign done_o      = (state_q == S_FINISH);
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
    assign timeout_o   = timeout_q;
    assign m_valid_o   = (state_q == S_ISSUE);
    assign m_mode_o    = (state_q == S_ISSUE) ? mode_q : 1'b0;
    assign m_addr_o    = (state_q == S_ISSUE) ? (BASE_ADDR + ADDR_WIDTH'(idx_q)) : '0;
    assign m_wdata_o   = (state_q == S_ISSUE) ? exp_data : '0;

endmodule
